aes_job_scheduler: RTL and testbench

Parametrised multi-channel front end for the AES datapath. It accepts 128-bit blocks from NUM_CH independent producer channels, each with its own encrypt/decrypt mode. It grants channels round-robin, issues one block at a time to the single AES core with a start pulse, and returns each result tagged with its source channel. A watchdog timeout produces a flagged error result instead of a hang. It sits between the AHB-side channel FIFOs and the AES block, replacing the single-channel read_fifo/data_done handshake.

---
 rtl/aes_job_scheduler_if.sv | 59 +++++
 rtl/aes_job_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_aes_job_scheduler.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_job_scheduler_if.sv
// aes_job_scheduler_if
// Bundles the channel-side, core-side and result-side signals of the AES job
// scheduler so that the scheduler and its environment share one connection.
//
// Signals:
//   ch_valid/ch_enable/ch_encrypt [NUM_CH]  per-channel request, enable, mode
//   ch_data [NUM_CH*DATA_W]                 channel i at [i*DATA_W +: DATA_W]
//   ch_ready [NUM_CH]                       one-hot accept strobe
//   core_start/core_is_encrypt/core_data    block issued to the AES core
//   core_done/core_result                   result returned by the AES core
//   res_valid/res_ready                     result handshake
//   res_data/res_ch/res_error               result payload, source tag, timeout flag
//   err_count [8]                           saturating timeout count
//
// Modports:
//   master  the scheduler's view
//   slave   the environment's view (channel FIFOs, AES core, consumer)
interface aes_job_scheduler_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 128,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic [NUM_CH-1:0]        ch_valid;
    logic [NUM_CH-1:0]        ch_enable;
    logic [NUM_CH-1:0]        ch_encrypt;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [NUM_CH-1:0]        ch_ready;

    logic                     core_start;
    logic                     core_is_encrypt;
    logic [DATA_W-1:0]        core_data;
    logic                     core_done;
    logic [DATA_W-1:0]        core_result;

    logic                     res_valid;
    logic                     res_ready;
    logic [DATA_W-1:0]        res_data;
    logic [CH_W-1:0]          res_ch;
    logic                     res_error;
    logic [7:0]               err_count;

    modport master (
        input  ch_valid, ch_enable, ch_encrypt, ch_data,
        output ch_ready,
        output core_start, core_is_encrypt, core_data,
        input  core_done, core_result,
        output res_valid, res_data, res_ch, res_error, err_count,
        input  res_ready
    );

    modport slave (
        output ch_valid, ch_enable, ch_encrypt, ch_data,
        input  ch_ready,
        input  core_start, core_is_encrypt, core_data,
        output core_done, core_result,
        input  res_valid, res_data, res_ch, res_error, err_count,
        output res_ready
    );
endinterface

// File: rtl/aes_job_scheduler.sv
// aes_job_scheduler
// Multi-channel front end for a single AES core. Channels that are valid and
// enabled are granted round-robin, one block at a time is issued to the core
// with a start pulse, and the result is returned tagged with its source
// channel. A watchdog turns a missing core_done into a flagged error result.
//
// Ports:
//   HCLK     clock, all logic on the rising edge
//   HRESET   synchronous active-high reset
//   bus      aes_job_scheduler_if.master (channel, core and result signals)
module aes_job_scheduler #(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 128,
    parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int TIMEOUT = 255
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    aes_job_scheduler_if.master  bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t              state;
    state_t              next_state;
    logic [CH_W-1:0]     last_grant;
    logic [CH_W-1:0]     lat_ch;
    logic [DATA_W-1:0]   lat_data;
    logic                lat_enc;
    logic [DATA_W-1:0]   res_data_q;
    logic                res_error_q;
    logic [7:0]          err_count_q;
    logic [15:0]         timer;

    logic [NUM_CH-1:0]   eligible;
    logic                grant_found;
    logic [CH_W-1:0]     grant_idx;
    logic                upper_found;
    logic [CH_W-1:0]     upper_idx;
    logic [CH_W-1:0]     any_idx;
    logic [DATA_W-1:0]   grant_data;
    logic                grant_enc;
    logic                timeout_hit;
    logic [NUM_CH-1:0]   ch_ready_c;
    logic                core_start_c;
    logic                res_valid_c;

    assign eligible    = bus.ch_valid & bus.ch_enable;
    assign timeout_hit = (timer == 16'(TIMEOUT));

    // Round-robin pick: the lowest eligible channel above last_grant wins;
    // if there is none, wrap around to the lowest eligible channel overall.
    // Scanning downward leaves the lowest match in each candidate.
    always_comb begin
        grant_found = 1'b0;
        upper_found = 1'b0;
        upper_idx   = '0;
        any_idx     = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                grant_found = 1'b1;
                any_idx     = CH_W'(i);
                if (i > int'(last_grant)) begin
                    upper_found = 1'b1;
                    upper_idx   = CH_W'(i);
                end
            end
        end
        grant_idx = upper_found ? upper_idx : any_idx;
    end

    // Select the granted channel's block and mode.
    always_comb begin
        grant_data = '0;
        grant_enc  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (CH_W'(i) == grant_idx) begin
                grant_data = bus.ch_data[i*DATA_W +: DATA_W];
                grant_enc  = bus.ch_encrypt[i];
            end
        end
    end

    // State register.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control outputs. ch_ready is held off during reset so
    // that a request seen in a reset cycle is never acknowledged without
    // being latched.
    always_comb begin
        next_state   = state;
        ch_ready_c   = '0;
        core_start_c = 1'b0;
        res_valid_c  = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found && !HRESET) begin
                    ch_ready_c = NUM_CH'(1) << grant_idx;
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                core_start_c = 1'b1;
                next_state   = WAIT;
            end
            WAIT: begin
                if (bus.core_done || timeout_hit) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                res_valid_c = 1'b1;
                if (bus.res_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Job datapath: latch the granted block, run the watchdog, capture the
    // result. core_done wins over a coinciding timeout. last_grant moves only
    // when a result is handed off, so skipped or disabled channels never
    // disturb the rotation.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            last_grant  <= CH_W'(NUM_CH - 1);
            lat_ch      <= '0;
            lat_data    <= '0;
            lat_enc     <= 1'b0;
            res_data_q  <= '0;
            res_error_q <= 1'b0;
            err_count_q <= '0;
            timer       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        lat_ch   <= grant_idx;
                        lat_data <= grant_data;
                        lat_enc  <= grant_enc;
                    end
                end
                ISSUE: begin
                    timer <= '0;
                end
                WAIT: begin
                    if (bus.core_done) begin
                        res_data_q  <= bus.core_result;
                        res_error_q <= 1'b0;
                    end else if (timeout_hit) begin
                        res_data_q  <= '0;
                        res_error_q <= 1'b1;
                        if (err_count_q != 8'hFF) begin
                            err_count_q <= err_count_q + 8'd1;
                        end
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                HOLD: begin
                    if (bus.res_ready) begin
                        last_grant <= lat_ch;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ch_ready        = ch_ready_c;
    assign bus.core_start      = core_start_c;
    assign bus.core_is_encrypt = lat_enc;
    assign bus.core_data       = lat_data;
    assign bus.res_valid       = res_valid_c;
    assign bus.res_data        = res_data_q;
    assign bus.res_ch          = lat_ch;
    assign bus.res_error       = res_error_q;
    assign bus.err_count       = err_count_q;

endmodule

// File: tb/tb_aes_job_scheduler.sv
// tb_aes_job_scheduler
// Directed bench for aes_job_scheduler with NUM_CH=4, DATA_W=128, TIMEOUT=10.
// Inputs change and outputs are sampled just after the rising edge, never on it.
module tb_aes_job_scheduler;

    logic HCLK;
    logic HRESET;

    int checks;
    int errors;
    int n;

    logic [127:0] data_tab [4];
    logic [127:0] fair_res [6];
    logic [3:0]   enc_pat;

    aes_job_scheduler_if #(.NUM_CH(4), .DATA_W(128), .CH_W(2)) bus ();

    aes_job_scheduler #(
        .NUM_CH(4),
        .DATA_W(128),
        .CH_W(2),
        .TIMEOUT(10)
    ) dut (
        .HCLK(HCLK),
        .HRESET(HRESET),
        .bus(bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [127:0] observed,
                                input logic [127:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] valid, input logic [3:0] enable,
                                  input logic [3:0] encrypt);
        bus.ch_valid   = valid;
        bus.ch_enable  = enable;
        bus.ch_encrypt = encrypt;
    endtask

    // Serve one job from an IDLE cycle in which the grant to 'ch' is expected.
    // core_done arrives after wait_cycles idle WAIT cycles; result taken at once.
    task automatic run_job(input int ch, input logic enc, input logic [127:0] din,
                           input logic [127:0] dout, input int wait_cycles,
                           input bit drop_valid);
        #1;
        check_output("grant_ready", bus.ch_ready, 128'(4'b0001 << ch));
        tick();
        if (drop_valid) bus.ch_valid = bus.ch_valid & ~(4'b0001 << ch);
        #1;
        check_output("issue_start", bus.core_start, 128'(1));
        check_output("issue_data", bus.core_data, din);
        check_output("issue_mode", bus.core_is_encrypt, 128'(enc));
        check_output("issue_no_ready", bus.ch_ready, 128'(0));
        tick();
        for (int i = 0; i < wait_cycles; i++) begin
            #1;
            check_output("wait_no_result", bus.res_valid, 128'(0));
            tick();
        end
        bus.core_done   = 1'b1;
        bus.core_result = dout;
        tick();
        bus.core_done   = 1'b0;
        bus.core_result = '0;
        #1;
        check_output("hold_valid", bus.res_valid, 128'(1));
        check_output("hold_ch", bus.res_ch, 128'(ch));
        check_output("hold_data", bus.res_data, dout);
        check_output("hold_error", bus.res_error, 128'(0));
        check_output("hold_no_ready", bus.ch_ready, 128'(0));
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        data_tab[0] = 128'h0123456789abcdef0f1e2d3c4b5a6978;
        data_tab[1] = 128'h00112233445566778899aabbccddeeff;
        data_tab[2] = 128'hdeadbeefcafef00d13572468a5a55a5a;
        data_tab[3] = 128'hfedcba98765432100123456789abcdef;
        fair_res[0] = 128'h11111111111111111111111111111111;
        fair_res[1] = 128'h22222222222222222222222222222222;
        fair_res[2] = 128'h33333333333333333333333333333333;
        fair_res[3] = 128'h44444444444444444444444444444444;
        fair_res[4] = 128'h55555555555555555555555555555555;
        fair_res[5] = 128'h66666666666666666666666666666666;

        HRESET          = 1'b1;
        apply_stimulus(4'b0000, 4'b0000, 4'b0000);
        bus.ch_data     = {data_tab[3], data_tab[2], data_tab[1], data_tab[0]};
        bus.core_done   = 1'b0;
        bus.core_result = '0;
        bus.res_ready   = 1'b0;

        // Reset held for two cycles: every output is zero.
        tick();
        tick();
        check_output("rst_ch_ready", bus.ch_ready, 128'(0));
        check_output("rst_core_start", bus.core_start, 128'(0));
        check_output("rst_core_enc", bus.core_is_encrypt, 128'(0));
        check_output("rst_core_data", bus.core_data, 128'(0));
        check_output("rst_res_valid", bus.res_valid, 128'(0));
        check_output("rst_res_data", bus.res_data, 128'(0));
        check_output("rst_res_ch", bus.res_ch, 128'(0));
        check_output("rst_res_error", bus.res_error, 128'(0));
        check_output("rst_err_count", bus.err_count, 128'(0));
        HRESET = 1'b0;
        apply_stimulus(4'b0000, 4'b1111, 4'b0000);
        tick();

        // Lone request on channel 2.
        apply_stimulus(4'b0100, 4'b1111, 4'b0100);
        run_job(2, 1'b1, data_tab[2], 128'hc0ffee00c0ffee00c0ffee00c0ffee00, 0, 1'b0);
        bus.ch_valid = 4'b0000;

        // core_done in IDLE is ignored.
        bus.core_done   = 1'b1;
        bus.core_result = 128'hbad0bad0bad0bad0bad0bad0bad0bad0;
        tick();
        bus.core_done   = 1'b0;
        bus.core_result = '0;
        check_output("idle_done_valid", bus.res_valid, 128'(0));
        check_output("idle_done_start", bus.core_start, 128'(0));
        tick();
        check_output("idle_done_valid2", bus.res_valid, 128'(0));

        // ch0 drops valid right after its grant; the job still completes.
        apply_stimulus(4'b0001, 4'b1111, 4'b0000);
        run_job(0, 1'b0, data_tab[0], 128'h0badf00d0badf00d0badf00d0badf00d, 2, 1'b1);
        check_output("drop_valid_gone", bus.ch_valid, 128'(0));

        // Fairness from reset: all channels busy, grants 0,1,2,3,0,1.
        HRESET = 1'b1;
        tick();
        HRESET  = 1'b0;
        enc_pat = 4'b1010;
        apply_stimulus(4'b1111, 4'b1111, enc_pat);
        for (int k = 0; k < 6; k++) begin
            run_job(k % 4, enc_pat[2'(k % 4)], data_tab[k % 4], fair_res[k], 1, 1'b0);
        end
        bus.ch_valid = 4'b0000;

        // Per-channel mode: ch1 encrypts, ch3 decrypts.
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        apply_stimulus(4'b1010, 4'b1111, 4'b0010);
        run_job(1, 1'b1, data_tab[1], 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0, 1'b0);
        bus.ch_valid = 4'b1000;
        run_job(3, 1'b0, data_tab[3], 128'h8899aabbccddeeff0011223344556677, 3, 1'b0);

        // Masking: ch0 would be first after ch3 but is disabled.
        apply_stimulus(4'b0011, 4'b1110, 4'b0010);
        run_job(1, 1'b1, data_tab[1], 128'h0f0e0d0c0b0a09080706050403020100, 0, 1'b0);
        bus.ch_valid = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_output("mask_no_ready", bus.ch_ready, 128'(0));
            check_output("mask_no_start", bus.core_start, 128'(0));
            tick();
        end

        // Timeout: no core_done, result 13 cycles after the grant.
        apply_stimulus(4'b0001, 4'b1111, 4'b0000);
        bus.core_result = 128'hdeaddeaddeaddeaddeaddeaddeaddead;
        #1;
        check_output("to_grant", bus.ch_ready, 128'(1));
        tick();
        bus.ch_valid = 4'b1111;
        #1;
        check_output("to_start", bus.core_start, 128'(1));
        for (int i = 2; i <= 12; i++) tick();
        check_output("to_not_yet", bus.res_valid, 128'(0));
        tick();
        check_output("to_valid", bus.res_valid, 128'(1));
        check_output("to_error", bus.res_error, 128'(1));
        check_output("to_data", bus.res_data, 128'(0));
        check_output("to_ch", bus.res_ch, 128'(0));
        check_output("to_count", bus.err_count, 128'(1));

        // Backpressure: result held, no new grants.
        for (int i = 0; i < 20; i++) begin
            tick();
            check_output("bp_no_ready", bus.ch_ready, 128'(0));
            check_output("bp_valid", bus.res_valid, 128'(1));
            check_output("bp_data", bus.res_data, 128'(0));
            check_output("bp_error", bus.res_error, 128'(1));
            check_output("bp_ch", bus.res_ch, 128'(0));
        end
        bus.ch_valid  = 4'b0000;
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check_output("bp_release", bus.res_valid, 128'(0));

        // 299 more timeouts: err_count saturates at 255.
        bus.ch_valid  = 4'b0001;
        bus.res_ready = 1'b1;
        for (int j = 0; j < 299; j++) begin
            n = 0;
            while (!bus.res_valid && n < 20) begin
                tick();
                n++;
            end
            check_output("sat_res_valid", bus.res_valid, 128'(1));
            check_output("sat_res_error", bus.res_error, 128'(1));
            tick();
        end
        bus.ch_valid    = 4'b0000;
        bus.res_ready   = 1'b0;
        bus.core_result = '0;
        check_output("sat_count", bus.err_count, 128'(255));

        // Reset during WAIT: back to IDLE, nothing emitted, count cleared.
        bus.ch_valid = 4'b0100;
        #1;
        check_output("mid_grant", bus.ch_ready, 128'(4));
        tick();
        bus.ch_valid = 4'b0000;
        tick();
        tick();
        HRESET = 1'b1;
        tick();
        check_output("mid_rst_valid", bus.res_valid, 128'(0));
        check_output("mid_rst_count", bus.err_count, 128'(0));
        check_output("mid_rst_start", bus.core_start, 128'(0));
        check_output("mid_rst_data", bus.core_data, 128'(0));
        HRESET = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            check_output("mid_rst_quiet", bus.res_valid, 128'(0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
